// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Purpose: shares a single RAM port between three requesters: the data
// stage (d), the instruction fetch (f, read-only) and a loader/DMA engine
// (l). Grants are combinational in the request cycle and drive the RAM
// address/data/byte-enable/write-enable directly. Read responses come back
// one cycle later on the shared rdata_o, and the per-requester rvalid pulses
// say who they belong to.
//
// Priority: d > f > l. The loader can lock the port across several cycles
// by holding l_lock_i after it has been granted.
//
// Optional feature (macro ARB_STARVE_GUARD_EN): a starvation counter for the
// loader. Once the loader has waited STARVE_LIMIT cycles it wins the next
// arbitration. With the macro undefined the priority is strictly fixed and
// the loader may wait indefinitely.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   d_req_i, d_we_i         data-stage request / write
//   d_addr_i, d_wdata_i     data-stage byte address / write data
//   d_byteen_i              data-stage byte enables
//   d_gnt_o, d_rvalid_o     data grant / read data valid
//   f_req_i, f_addr_i       fetch request / byte address
//   f_gnt_o, f_rvalid_o     fetch grant / read data valid
//   l_req_i, l_lock_i       loader request / lock hold
//   l_we_i                  loader write
//   l_addr_i, l_wdata_i     loader byte address / write data
//   l_byteen_i              loader byte enables
//   l_gnt_o, l_rvalid_o     loader grant / read data valid
//   ram_addr_o              word address to the RAM
//   ram_data_o              RAM write data
//   ram_byteen_o            RAM byte enables
//   ram_wren_o              RAM write enable
//   ram_q_i                 RAM read data (one-cycle registered latency)
//   rdata_o                 shared read data (copy of ram_q_i)
//
// FSM:
//   state     | meaning
//   ST_IDLE   | normal fixed-priority arbitration (plus starvation guard)
//   ST_LOCKED | loader owns the port while it keeps l_req_i and l_lock_i

module ram_port_arbiter #(
  parameter logic [3:0] STARVE_LIMIT = 4'd15
) (
  input  logic        clk_i,
  input  logic        reset_i,

  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_byteen_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,

  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_rvalid_o,

  input  logic        l_req_i,
  input  logic        l_lock_i,
  input  logic        l_we_i,
  input  logic [31:0] l_addr_i,
  input  logic [31:0] l_wdata_i,
  input  logic [3:0]  l_byteen_i,
  output logic        l_gnt_o,
  output logic        l_rvalid_o,

  output logic [29:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [3:0]  ram_byteen_o,
  output logic        ram_wren_o,
  input  logic [31:0] ram_q_i,
  output logic [31:0] rdata_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_D    = 2'd1,
    SRC_F    = 2'd2,
    SRC_L    = 2'd3
  } src_e;

  state_e     state_q, state_d;
  src_e       win;

  // Read-response tags, one bit per requester: {l, f, d}.
  logic [2:0] rvalid_q, rvalid_d;

  logic       starve_hit;

  // Byte-offset bits never reach the word-addressed RAM.
  logic       unused_addr_lsbs;
  assign unused_addr_lsbs = ^{d_addr_i[1:0], f_addr_i[1:0], l_addr_i[1:0]};

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign starve_hit = (starve_q == STARVE_LIMIT);

  // Counts loader wait cycles, saturating at the limit; any loader grant
  // (normal, locked or forced) clears it.
  always_comb begin
    starve_d = starve_q;
    if (win == SRC_L) begin
      starve_d = 4'd0;
    end else if (l_req_i && (starve_q != STARVE_LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end
`else
  logic       unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign starve_hit          = 1'b0;
`endif

  // Winner selection. Reset suppresses every grant. In LOCKED the loader
  // keeps the port as long as it holds both req and lock; the cycle it
  // drops either one falls through to the normal IDLE rules.
  always_comb begin
    win = SRC_NONE;
    if (reset_i) begin
      win = SRC_NONE;
    end else if ((state_q == ST_LOCKED) && l_req_i && l_lock_i) begin
      win = SRC_L;
    end else if (starve_hit && l_req_i) begin
      win = SRC_L;
    end else if (d_req_i) begin
      win = SRC_D;
    end else if (f_req_i) begin
      win = SRC_F;
    end else if (l_req_i) begin
      win = SRC_L;
    end
  end

  // The lock is only taken or kept on a cycle where the loader is granted
  // while asserting l_lock_i.
  always_comb begin
    state_d = ST_IDLE;
    if ((win == SRC_L) && l_lock_i) begin
      state_d = ST_LOCKED;
    end
  end

  // RAM port mux and response tagging. Idle bus drives all zeros.
  always_comb begin
    d_gnt_o      = 1'b0;
    f_gnt_o      = 1'b0;
    l_gnt_o      = 1'b0;
    ram_addr_o   = 30'd0;
    ram_data_o   = 32'd0;
    ram_byteen_o = 4'd0;
    ram_wren_o   = 1'b0;
    rvalid_d     = 3'b000;
    case (win)
      SRC_D: begin
        d_gnt_o      = 1'b1;
        ram_addr_o   = d_addr_i[31:2];
        ram_data_o   = d_wdata_i;
        ram_byteen_o = d_byteen_i;
        ram_wren_o   = d_we_i;
        rvalid_d[0]  = ~d_we_i;
      end
      SRC_F: begin
        f_gnt_o      = 1'b1;
        ram_addr_o   = f_addr_i[31:2];
        ram_byteen_o = 4'b1111;
        rvalid_d[1]  = 1'b1;
      end
      SRC_L: begin
        l_gnt_o      = 1'b1;
        ram_addr_o   = l_addr_i[31:2];
        ram_data_o   = l_wdata_i;
        ram_byteen_o = l_byteen_i;
        ram_wren_o   = l_we_i;
        rvalid_d[2]  = ~l_we_i;
      end
      default: begin
        rvalid_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      rvalid_q <= 3'b000;
`ifdef ARB_STARVE_GUARD_EN
      starve_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q <= starve_d;
`endif
    end
  end

  // A response tag still sitting in the pipeline is hidden during the reset
  // cycle so nothing stale escapes while reset is asserted.
  assign d_rvalid_o = rvalid_q[0] & ~reset_i;
  assign f_rvalid_o = rvalid_q[1] & ~reset_i;
  assign l_rvalid_o = rvalid_q[2] & ~reset_i;

  assign rdata_o = ram_q_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam logic [3:0] LIM = 4'd3;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_byteen_i;
  logic        d_gnt_o, d_rvalid_o;
  logic        f_req_i;
  logic [31:0] f_addr_i;
  logic        f_gnt_o, f_rvalid_o;
  logic        l_req_i, l_lock_i, l_we_i;
  logic [31:0] l_addr_i, l_wdata_i;
  logic [3:0]  l_byteen_i;
  logic        l_gnt_o, l_rvalid_o;
  logic [29:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_byteen_o;
  logic        ram_wren_o;
  logic [31:0] ram_q_i;
  logic [31:0] rdata_o;

  ram_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_byteen_i(d_byteen_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i),
    .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o),
    .l_req_i(l_req_i), .l_lock_i(l_lock_i), .l_we_i(l_we_i),
    .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i), .l_byteen_i(l_byteen_i),
    .l_gnt_o(l_gnt_o), .l_rvalid_o(l_rvalid_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_byteen_o(ram_byteen_o), .ram_wren_o(ram_wren_o),
    .ram_q_i(ram_q_i), .rdata_o(rdata_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the
  // falling edge.
  task automatic nxt();
    @(posedge clk_i);
    #1;
    ram_q_i = $urandom;
  endtask

  // Reference model: who owns the port, whether the loader holds a lock,
  // how long the loader has waited, and which read answer is due next cycle.
  bit m_locked = 1'b0;
  int m_cnt    = 0;
  int m_pend   = -1;   // -1 none, 0 d, 1 f, 2 l

  function automatic int pick();
    if (reset_i) return -1;
    if (m_locked && l_req_i && l_lock_i) return 2;
`ifdef ARB_STARVE_GUARD_EN
    if (l_req_i && (m_cnt == int'(LIM))) return 2;
`endif
    if (d_req_i) return 0;
    if (f_req_i) return 1;
    if (l_req_i) return 2;
    return -1;
  endfunction

  always @(negedge clk_i) begin
    int          w;
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    logic        ew;
    w  = pick();
    ea = 32'd0; ed = 32'd0; eb = 4'd0; ew = 1'b0;
    case (w)
      0: begin ea = d_addr_i / 4; ed = d_wdata_i; eb = d_byteen_i; ew = d_we_i; end
      1: begin ea = f_addr_i / 4; eb = 4'hF; end
      2: begin ea = l_addr_i / 4; ed = l_wdata_i; eb = l_byteen_i; ew = l_we_i; end
      default: ;
    endcase
    chk("d_gnt",     {31'd0, d_gnt_o},  {31'd0, w == 0});
    chk("f_gnt",     {31'd0, f_gnt_o},  {31'd0, w == 1});
    chk("l_gnt",     {31'd0, l_gnt_o},  {31'd0, w == 2});
    chk("ram_addr",  {2'd0, ram_addr_o}, ea);
    chk("ram_data",  ram_data_o, ed);
    chk("ram_byteen", {28'd0, ram_byteen_o}, {28'd0, eb});
    chk("ram_wren",  {31'd0, ram_wren_o}, {31'd0, ew});
    chk("d_rvalid",  {31'd0, d_rvalid_o}, {31'd0, !reset_i && m_pend == 0});
    chk("f_rvalid",  {31'd0, f_rvalid_o}, {31'd0, !reset_i && m_pend == 1});
    chk("l_rvalid",  {31'd0, l_rvalid_o}, {31'd0, !reset_i && m_pend == 2});
    chk("rdata",     rdata_o, ram_q_i);
    if (reset_i) begin
      m_locked = 1'b0;
      m_cnt    = 0;
      m_pend   = -1;
    end else begin
      m_pend   = (w >= 0 && !ew) ? w : -1;
      m_locked = (w == 2) && l_lock_i;
      if (w == 2) m_cnt = 0;
      else if (l_req_i && m_cnt < int'(LIM)) m_cnt++;
    end
    cyc++;
  end

  initial begin
    reset_i = 1'b1;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_1234; d_wdata_i = 32'h1111_2222; d_byteen_i = 4'hF;
    f_req_i = 1'b1; f_addr_i = 32'h0000_0040;
    l_req_i = 1'b1; l_lock_i = 1'b1; l_we_i = 1'b0; l_addr_i = 32'h0000_0800;
    l_wdata_i = 32'd0; l_byteen_i = 4'hF;
    ram_q_i = 32'h0;

    // Reset dominates requests.
    @(negedge clk_i);
    chk("rst_gnts",  {29'd0, d_gnt_o, f_gnt_o, l_gnt_o}, 32'd0);
    chk("rst_wren",  {31'd0, ram_wren_o}, 32'd0);
    chk("rst_addr",  {2'd0, ram_addr_o}, 32'd0);
    chk("rst_be",    {28'd0, ram_byteen_o}, 32'd0);

    // All three read: d first, then f, then l, each answered one cycle later.
    nxt();
    reset_i = 1'b0;
    d_we_i = 1'b0; d_addr_i = 32'h100; f_addr_i = 32'h204; l_lock_i = 1'b0; l_addr_i = 32'h308;
    @(negedge clk_i);
    chk("t1_d_gnt", {31'd0, d_gnt_o}, 32'd1);
    chk("t1_addr",  {2'd0, ram_addr_o}, 32'h40);
    chk("t1_f_gnt", {31'd0, f_gnt_o}, 32'd0);
    nxt();
    d_req_i = 1'b0;
    @(negedge clk_i);
    chk("t1_d_rvalid", {31'd0, d_rvalid_o}, 32'd1);
    chk("t1_rdata",    rdata_o, ram_q_i);
    chk("t1_f_gnt2",   {31'd0, f_gnt_o}, 32'd1);
    chk("t1_f_addr",   {2'd0, ram_addr_o}, 32'h81);
    chk("t1_f_be",     {28'd0, ram_byteen_o}, 32'hF);
    nxt();
    f_req_i = 1'b0;
    @(negedge clk_i);
    chk("t1_l_gnt",    {31'd0, l_gnt_o}, 32'd1);
    chk("t1_l_addr",   {2'd0, ram_addr_o}, 32'hC2);
    chk("t1_f_rvalid", {31'd0, f_rvalid_o}, 32'd1);
    nxt();
    l_req_i = 1'b0;
    @(negedge clk_i);
    chk("t1_l_rvalid", {31'd0, l_rvalid_o}, 32'd1);

    // Data write beats a fetch; no read response for the write.
    nxt();
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h1006; d_wdata_i = 32'hDEAD_BEEF; d_byteen_i = 4'b0011;
    f_req_i = 1'b1; f_addr_i = 32'h40;
    @(negedge clk_i);
    chk("t2_addr",  {2'd0, ram_addr_o}, 32'h401);
    chk("t2_wren",  {31'd0, ram_wren_o}, 32'd1);
    chk("t2_f_gnt", {31'd0, f_gnt_o}, 32'd0);
    chk("t2_be",    {28'd0, ram_byteen_o}, 32'h3);
    chk("t2_data",  ram_data_o, 32'hDEAD_BEEF);
    nxt();
    d_req_i = 1'b0; d_we_i = 1'b0;
    @(negedge clk_i);
    chk("t2_no_d_rvalid", {31'd0, d_rvalid_o}, 32'd0);
    chk("t2_f_gnt2",      {31'd0, f_gnt_o}, 32'd1);
    nxt();
    f_req_i = 1'b0;
    @(negedge clk_i);
    chk("t2_f_rvalid", {31'd0, f_rvalid_o}, 32'd1);

    // Loader lock holds off the data stage until the lock drops.
    nxt();
    l_req_i = 1'b1; l_lock_i = 1'b1; l_we_i = 1'b0; l_addr_i = 32'h500; l_byteen_i = 4'hF;
    @(negedge clk_i);
    chk("t3_l_gnt", {31'd0, l_gnt_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      nxt();
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h10; d_wdata_i = 32'hA5A5_0000; d_byteen_i = 4'hF;
      l_we_i = i[0]; l_wdata_i = 32'h100 + i; l_addr_i = 32'h504 + 4 * i; l_byteen_i = 4'b1100;
      @(negedge clk_i);
      chk("t3_d_held", {31'd0, d_gnt_o}, 32'd0);
      chk("t3_l_keep", {31'd0, l_gnt_o}, 32'd1);
    end
    nxt();
    l_lock_i = 1'b0; l_we_i = 1'b0;
    @(negedge clk_i);
    chk("t3_d_gnt_unlock", {31'd0, d_gnt_o}, 32'd1);
    chk("t3_l_wait",       {31'd0, l_gnt_o}, 32'd0);
    nxt();
    d_req_i = 1'b0; d_we_i = 1'b0;
    @(negedge clk_i);
    chk("t3_l_gnt2", {31'd0, l_gnt_o}, 32'd1);

    // Fetch and loader both continuously requesting.
    nxt();
    l_req_i = 1'b1; l_addr_i = 32'h600; f_req_i = 1'b1; f_addr_i = 32'h80;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (k == 3) begin
`ifdef ARB_STARVE_GUARD_EN
        chk("t4_l_forced", {31'd0, l_gnt_o}, 32'd1);
`else
        chk("t4_f_fixed", {31'd0, f_gnt_o}, 32'd1);
`endif
      end else begin
        chk("t4_f_gnt", {31'd0, f_gnt_o}, 32'd1);
      end
      nxt();
    end
    f_req_i = 1'b0; l_req_i = 1'b0;

    // Reset in the middle of a locked read burst.
    nxt();
    l_req_i = 1'b1; l_lock_i = 1'b1; l_we_i = 1'b0; l_addr_i = 32'h700;
    @(negedge clk_i);
    chk("t5_l_lock_gnt", {31'd0, l_gnt_o}, 32'd1);
    nxt();
    reset_i = 1'b1; d_req_i = 1'b1; d_addr_i = 32'h20;
    @(negedge clk_i);
    chk("t5_rst_gnts",   {29'd0, d_gnt_o, f_gnt_o, l_gnt_o}, 32'd0);
    chk("t5_rst_rvalid", {29'd0, d_rvalid_o, f_rvalid_o, l_rvalid_o}, 32'd0);
    chk("t5_rst_wren",   {31'd0, ram_wren_o}, 32'd0);
    chk("t5_rst_addr",   {2'd0, ram_addr_o}, 32'd0);
    nxt();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("t5_no_stale", {31'd0, l_rvalid_o}, 32'd0);
    chk("t5_idle_d",   {31'd0, d_gnt_o}, 32'd1);
    chk("t5_idle_l",   {31'd0, l_gnt_o}, 32'd0);
    nxt();
    d_req_i = 1'b0; l_req_i = 1'b0; l_lock_i = 1'b0;
    @(negedge clk_i);
    chk("t5_d_rvalid", {31'd0, d_rvalid_o}, 32'd1);
    nxt();
    nxt();
    @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
